// File: rtl/up_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : up_pack_pkg
// Purpose  : Shared types and helpers for the up_pack narrow-to-phrase
//            read-data packer: beat width codes, FSM state encoding and the
//            bytes-per-beat / lane alignment helpers.
// Macro    : UP_OVERRUN_EN (used by the files importing this package)
// Revision : 1.0  initial release
// ============================================================================
package up_pack_pkg;

    localparam int PHRASE_W = 64;   // assembled phrase width
    localparam int NARROW_W = 32;   // widest supported beat
    localparam int NLANES   = 8;    // byte lanes per phrase

    // Beat width codes; code 3 is accepted on the port and treated as W32.
    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2
    } width_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Bytes carried by one beat of the given width code (3 -> 4 bytes).
    function automatic logic [2:0] bytes_per_width(input logic [1:0] w);
        case (w)
            W8:      bytes_per_width = 3'd1;
            W16:     bytes_per_width = 3'd2;
            default: bytes_per_width = 3'd4;
        endcase
    endfunction

    // Clear the low address bits so the first beat lands width-aligned.
    function automatic logic [2:0] align_ptr(input logic [2:0] a, input logic [1:0] w);
        case (w)
            W8:      align_ptr = a;
            W16:     align_ptr = {a[2:1], 1'b0};
            default: align_ptr = {a[2], 2'b00};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/up_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : up_pack_if
// Purpose  : Bundles the up_pack transfer-control, narrow beat input and
//            phrase output handshake.
//            start/width/addr/nbeats : transfer request
//            din/din_valid           : narrow beat input
//            busy                    : transfer in progress
//            dout/dout_be/dout_valid : assembled phrase, lane enables, ready
//            dout_ack                : consumer took the phrase
//            overrun                 : sticky protocol error (UP_OVERRUN_EN)
//            slave modport  -> up_pack; master modport -> requester side.
// Revision : 1.0  initial release
// ============================================================================
interface up_pack_if;
    import up_pack_pkg::*;

    logic                  start;
    logic [1:0]            width;
    logic [2:0]            addr;
    logic [2:0]            nbeats;
    logic [NARROW_W-1:0]   din;
    logic                  din_valid;
    logic                  busy;
    logic [PHRASE_W-1:0]   dout;
    logic [NLANES-1:0]     dout_be;
    logic                  dout_valid;
    logic                  dout_ack;
`ifdef UP_OVERRUN_EN
    logic                  overrun;
`endif

    modport slave (
`ifdef UP_OVERRUN_EN
        output overrun,
`endif
        input  start, width, addr, nbeats, din, din_valid, dout_ack,
        output busy, dout, dout_be, dout_valid
    );

    modport master (
`ifdef UP_OVERRUN_EN
        input  overrun,
`endif
        output start, width, addr, nbeats, din, din_valid, dout_ack,
        input  busy, dout, dout_be, dout_valid
    );

endinterface
`default_nettype wire

// File: rtl/up_pack_lane_wr.sv
`default_nettype none
// ============================================================================
// Module   : up_lane_wr
// Purpose  : Combinational lane steering for one narrow beat. Places the
//            right-justified beat bytes into the phrase lanes starting at
//            ptr, wrapping from lane 7 back to lane 0.
// Ports    : width  in  2   beat width code (3 behaves as 32-bit)
//            ptr    in  3   first destination lane
//            din    in  32  beat data, right-justified
//            data   out 64  beat bytes placed in their lanes, others 0
//            mask   out 8   lanes written by this beat
// Revision : 1.0  initial release
// ============================================================================
module up_lane_wr
    import up_pack_pkg::*;
(
    input  logic [1:0]          width,
    input  logic [2:0]          ptr,
    input  logic [NARROW_W-1:0] din,
    output logic [PHRASE_W-1:0] data,
    output logic [NLANES-1:0]   mask
);

    logic [2:0] nbytes;
    logic [2:0] lane;

    always_comb begin
        data   = '0;
        mask   = '0;
        lane   = '0;
        nbytes = bytes_per_width(width);
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                // 3-bit add wraps modulo 8, giving the lane-7 -> lane-0 wrap
                lane                     = ptr + 3'(i);
                data[{lane, 3'b000} +: 8] = din[i*8 +: 8];
                mask[lane]               = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/up_pack.sv
`default_nettype none
// ============================================================================
// Module   : up_pack
// Purpose  : Collects 8/16/32-bit read beats into the byte lanes of a 64-bit
//            phrase register and presents the phrase with lane enables.
//            IDLE -> FILL on start; FILL -> HOLD after the last beat;
//            HOLD -> IDLE on dout_ack, or straight to FILL when start
//            accompanies dout_ack.
// Ports    : sys_clk  in   system clock
//            resetl   in   asynchronous active-low reset
//            bus      slave modport of up_pack_if (see that file)
// Params   : CLR_ON_START 1 = zero the phrase when a transfer starts
//            DIN_W        narrow input width, only 32 supported
// Macro    : UP_OVERRUN_EN adds the sticky overrun output
// Revision : 1.0  initial release
// ============================================================================
module up_pack
    import up_pack_pkg::*;
#(
    parameter bit CLR_ON_START = 1'b1,
    parameter int DIN_W        = 32
) (
    input  logic     sys_clk,
    input  logic     resetl,
    up_pack_if.slave bus
);

    state_t                state_q,  state_d;
    logic [1:0]            width_q,  width_d;
    logic [2:0]            ptr_q,    ptr_d;
    logic [2:0]            cnt_q,    cnt_d;
    logic [PHRASE_W-1:0]   dout_q,   dout_d;
    logic [NLANES-1:0]     be_q,     be_d;
`ifdef UP_OVERRUN_EN
    logic                  overrun_q, overrun_d;
`endif

    logic [DIN_W-1:0]      din_w;
    logic [PHRASE_W-1:0]   wr_data;
    logic [NLANES-1:0]     wr_mask;
    logic [PHRASE_W-1:0]   wr_mask_bits;
    logic                  start_accept;

    assign din_w = bus.din;

    up_lane_wr u_lane_wr (
        .width (width_q),
        .ptr   (ptr_q),
        .din   (din_w),
        .data  (wr_data),
        .mask  (wr_mask)
    );

    // Expand the lane mask to a bit mask for the merge into the phrase.
    always_comb begin
        wr_mask_bits = '0;
        for (int j = 0; j < NLANES; j++) begin
            wr_mask_bits[j*8 +: 8] = {8{wr_mask[j]}};
        end
    end

    // A start counts in IDLE, or in HOLD only when the phrase is being
    // acknowledged in the same cycle (back-to-back transfer).
    assign start_accept = bus.start &&
                          ((state_q == ST_IDLE) ||
                           ((state_q == ST_HOLD) && bus.dout_ack));

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        be_d    = be_q;

        case (state_q)
            ST_FILL: begin
                if (bus.din_valid) begin
                    dout_d = (dout_q & ~wr_mask_bits) | (wr_data & wr_mask_bits);
                    be_d   = be_q | wr_mask;
                    ptr_d  = ptr_q + bytes_per_width(width_q);
                    if (cnt_q == 3'd0) begin
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.dout_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_accept) begin
            // Width code 3 is normalised so later logic sees only 0..2.
            width_d = (bus.width == 2'd3) ? 2'(W32) : bus.width;
            ptr_d   = align_ptr(bus.addr, bus.width);
            cnt_d   = bus.nbeats;
            be_d    = '0;
            if (CLR_ON_START) begin
                dout_d = '0;
            end
            state_d = ST_FILL;
        end
    end

`ifdef UP_OVERRUN_EN
    // Set wins over clear so an event in the accepting cycle is not lost.
    always_comb begin
        overrun_d = overrun_q;
        if (start_accept) begin
            overrun_d = 1'b0;
        end
        if (((state_q != ST_FILL) && bus.din_valid) ||
            ((state_q == ST_FILL) && bus.start)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`endif

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_IDLE;
            width_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            be_q    <= be_d;
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.dout_valid = (state_q == ST_HOLD);
    assign bus.dout       = dout_q;
    assign bus.dout_be    = be_q;

endmodule
`default_nettype wire

// File: tb/tb_up_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_pack
// Purpose  : Self-checking bench for up_pack: directed phrases, back-to-back
//            acknowledge/start, randomized transfers against a byte-lane
//            reference model, and reset in the middle of a fill.
// Macro    : UP_OVERRUN_EN enables the overrun checks
// Revision : 1.0  initial release
// ============================================================================
module tb_up_pack;
    import up_pack_pkg::*;

    logic clk = 1'b0;
    logic resetl;

    always #5 clk = ~clk;

    up_pack_if bus ();

    up_pack dut (
        .sys_clk (clk),
        .resetl  (resetl),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one byte per lane, enables, next lane, beat size.
    logic [7:0] m_bytes [8];
    logic [7:0] m_be;
    int         m_ptr;
    int         m_bpw;
    bit         m_ovr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] m_dout();
        logic [63:0] r;
        for (int l = 0; l < 8; l++) r[l*8 +: 8] = m_bytes[l];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int l = 0; l < 8; l++) m_bytes[l] = 8'h00;
        m_be = 8'h00;
    endtask

    // Issue a start; with_ack also acknowledges a phrase in HOLD.
    task automatic start_xfer(input int w, input int a, input int nb, input bit with_ack);
        bus.start    = 1'b1;
        bus.width    = 2'(w);
        bus.addr     = 3'(a);
        bus.nbeats   = 3'(nb);
        bus.dout_ack = with_ack;
        tick();
        bus.start    = 1'b0;
        bus.dout_ack = 1'b0;
        m_bpw = (w == 0) ? 1 : (w == 1) ? 2 : 4;
        m_ptr = a - (a % m_bpw);
        m_clear();
        m_ovr = 1'b0;
        check("start_busy",  64'(bus.busy), 64'd1);
        check("start_valid", 64'(bus.dout_valid), 64'd0);
        check("start_be",    64'(bus.dout_be), 64'd0);
    endtask

    task automatic send_beat(input logic [31:0] d);
        bus.din       = d;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        for (int k = 0; k < m_bpw; k++) begin
            m_bytes[(m_ptr + k) % 8] = d[k*8 +: 8];
            m_be[(m_ptr + k) % 8]    = 1'b1;
        end
        m_ptr = (m_ptr + m_bpw) % 8;
    endtask

    // Idle cycle inside FILL carrying a stray start that must be ignored.
    task automatic fill_gap();
        bus.start  = 1'b1;
        bus.width  = 2'($urandom_range(0, 3));
        bus.addr   = 3'($urandom_range(0, 7));
        bus.nbeats = 3'($urandom_range(0, 7));
        tick();
        bus.start  = 1'b0;
        m_ovr      = 1'b1;
    endtask

    task automatic check_phrase(input string tag);
        check({tag, "_valid"}, 64'(bus.dout_valid), 64'd1);
        check({tag, "_dout"},  bus.dout, m_dout());
        check({tag, "_be"},    64'(bus.dout_be), 64'(m_be));
`ifdef UP_OVERRUN_EN
        check({tag, "_ovr"},   64'(bus.overrun), 64'(m_ovr));
`endif
    endtask

    // Stray beats in HOLD must not disturb the phrase; then acknowledge.
    task automatic hold_and_ack(input string tag, input int stray);
        for (int s = 0; s < stray; s++) begin
            bus.din       = $urandom;
            bus.din_valid = 1'b1;
            tick();
            bus.din_valid = 1'b0;
            m_ovr         = 1'b1;
        end
        if (stray > 0) check_phrase({tag, "_hold"});
        bus.dout_ack = 1'b1;
        tick();
        bus.dout_ack = 1'b0;
        check({tag, "_ack_valid"}, 64'(bus.dout_valid), 64'd0);
        check({tag, "_ack_busy"},  64'(bus.busy), 64'd0);
    endtask

    function automatic logic [31:0] junk_hi(input logic [31:0] v, input int bytes);
        logic [31:0] r;
        r = $urandom;
        for (int k = 0; k < bytes; k++) r[k*8 +: 8] = v[k*8 +: 8];
        return r;
    endfunction

    initial begin
        resetl        = 1'b0;
        bus.start     = 1'b0;
        bus.width     = '0;
        bus.addr      = '0;
        bus.nbeats    = '0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.dout_ack  = 1'b0;
        m_clear();
        m_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout",  bus.dout, 64'd0);
        check("rst_be",    64'(bus.dout_be), 64'd0);
        check("rst_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_busy",  64'(bus.busy), 64'd0);
`ifdef UP_OVERRUN_EN
        check("rst_ovr",   64'(bus.overrun), 64'd0);
`endif
        @(negedge clk);
        resetl = 1'b1;
        tick();

        // 8-bit, eight beats filling the whole phrase
        start_xfer(0, 0, 7, 1'b0);
        for (int b = 1; b <= 8; b++) begin
            send_beat(junk_hi(32'(b * 8'h11), 1));
            if (b == 7) check("t8_early_valid", 64'(bus.dout_valid), 64'd0);
        end
        check("t8_dout", bus.dout, 64'h8877665544332211);
        check("t8_be",   64'(bus.dout_be), 64'hFF);
        check_phrase("t8");
        hold_and_ack("t8", 0);

        // 16-bit, addr 3 aligned down to 2
        start_xfer(1, 3, 1, 1'b0);
        send_beat(junk_hi(32'hAAAA, 2));
        send_beat(junk_hi(32'hBBBB, 2));
        check("t16_dout", bus.dout, 64'h0000BBBBAAAA0000);
        check("t16_be",   64'(bus.dout_be), 64'h3C);
        check_phrase("t16");
        hold_and_ack("t16", 1);

        // 32-bit wrap from lane 4 around to lane 0
        start_xfer(2, 4, 1, 1'b0);
        send_beat(32'hDEADBEEF);
        send_beat(32'h01234567);
        check("t32_dout", bus.dout, 64'hDEADBEEF01234567);
        check("t32_be",   64'(bus.dout_be), 64'hFF);
        check_phrase("t32");

        // Acknowledge and new start in the same cycle
        start_xfer(0, 5, 0, 1'b1);
        send_beat(junk_hi(32'h5A, 1));
        check("b2b_dout", bus.dout, 64'h00005A0000000000);
        check("b2b_be",   64'(bus.dout_be), 64'h20);
        check_phrase("b2b");
        hold_and_ack("b2b", 0);

        // Randomized transfers
        for (int t = 0; t < 30; t++) begin
            int w, nb;
            w  = $urandom_range(0, 3);
            nb = $urandom_range(0, 7);
            start_xfer(w, $urandom_range(0, 7), nb, 1'b0);
            for (int b = 0; b <= nb; b++) begin
                if ($urandom_range(0, 3) == 0) fill_gap();
                if (b == nb) check("rnd_early_valid", 64'(bus.dout_valid), 64'd0);
                send_beat($urandom);
            end
            check_phrase("rnd");
            hold_and_ack("rnd", $urandom_range(0, 2));
        end

        // Reset in the middle of a fill
        start_xfer(1, 0, 3, 1'b0);
        send_beat($urandom);
        send_beat($urandom);
        resetl = 1'b0;
        #1;
        check("mrst_dout",  bus.dout, 64'd0);
        check("mrst_be",    64'(bus.dout_be), 64'd0);
        check("mrst_valid", 64'(bus.dout_valid), 64'd0);
        check("mrst_busy",  64'(bus.busy), 64'd0);
        @(negedge clk);
        resetl = 1'b1;
        for (int s = 0; s < 3; s++) begin
            bus.din       = $urandom;
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        tick();
        check("idle_dout",  bus.dout, 64'd0);
        check("idle_be",    64'(bus.dout_be), 64'd0);
        check("idle_valid", 64'(bus.dout_valid), 64'd0);
        check("idle_busy",  64'(bus.busy), 64'd0);
`ifdef UP_OVERRUN_EN
        check("idle_ovr_set",  64'(bus.overrun), 64'd1);
        tick();
        check("idle_ovr_held", 64'(bus.overrun), 64'd1);
        start_xfer(2, 0, 0, 1'b0);
        check("ovr_cleared",   64'(bus.overrun), 64'd0);
        send_beat(32'hCAFEF00D);
        check_phrase("ovr");
        hold_and_ack("ovr", 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
